dbus_arbiter: RTL and testbench
===============================

Name: dbus_arbiter

Overview:
Two-port arbiter and sequencer for the shared data-memory / memory-mapped I/O bus.
- Requester 0 is the CPU memory stage; requester 1 is a DMA/debug port.
- It grants one requester at a time, drives registered address, data and strobes to the data memory and I/O devices, and splits writes into mem_we/io_we by address prefix.
- It returns read data with a one-cycle-pulse ack.
- CPU has priority; a starvation counter guarantees DMA progress.

Parameters:
DBITS, 32, data and address width
IO_PREFIX, 4'hF, value of addr[31:28] that selects I/O space
STARVE_LIMIT, 8, number of consecutive denied DMA cycles after which DMA wins arbitration
CNT_BITS, 4, starvation counter width; must satisfy 2^CNT_BITS > STARVE_LIMIT

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
cpu_req  in  1  CPU request; held with its fields stable until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  DBITS  byte address
cpu_wdata  in  DBITS  write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DBITS  read data; valid when cpu_ack is high, held until the next CPU read completes
dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata  same as the cpu_* ports, for requester 1
bus_addr  out  DBITS  registered address to data memory and I/O
bus_wdata  out  DBITS  registered write data
bus_re  out  1  read strobe
mem_we  out  1  data-memory write enable
io_we  out  1  I/O write enable
bus_rdata  in  DBITS  read data; memory and I/O respond one cycle after bus_re
busy  out  1  high in every state except IDLE
grant_id  out  1  0 = CPU, 1 = DMA; valid while busy is high

Behaviour:
- Reset (reset == 0 at a clk edge):
  - state = IDLE, starvation count = 0.
  - All outputs 0, including both rdata registers.
  - Reset mid-transaction aborts it: no ack is issued, and strobes are 0 from the next cycle.
- States: IDLE, ISSUE, RESP, DONE.
- IDLE, arbitration on the sampled req signals:
  - Only one requester: grant it.
  - Both requesting: DMA wins if count >= STARVE_LIMIT, otherwise CPU wins.
  - No request: stay in IDLE.
  - On a grant, latch grant_id, we, addr and wdata into the bus registers; next state is ISSUE.
- ISSUE:
  - bus_addr and bus_wdata are valid.
  - Write to an address with prefix == IO_PREFIX: io_we = 1. Other write addresses: mem_we = 1.
  - Read: bus_re = 1.
  - Next state: write -> DONE; read -> RESP.
- RESP:
  - All strobes 0.
  - Capture bus_rdata into the granted requester's rdata register.
  - Next state is DONE.
- DONE:
  - ack = 1 for grant_id only; strobes 0.
  - Next state is IDLE unconditionally. This ensures a requester that drops req after ack is never re-granted.
- Latency, with req first sampled in IDLE at cycle 0:
  - Write: ISSUE at cycle 1, ack at cycle 2.
  - Read: ISSUE at cycle 1, RESP at cycle 2, ack and rdata at cycle 3.
  - Earliest next grant is decided at cycle 3 (write) or cycle 4 (read).
- bus_addr and bus_wdata hold their last values outside ISSUE/RESP. mem_we, io_we and bus_re are 0 outside ISSUE.
- The two write enables are mutually exclusive; mem_we and io_we are never both 1.
- Starvation counter:
  - Increments in any cycle where dma_req = 1 and DMA is not the granted requester of an in-flight transaction.
  - Saturates at its maximum value.
  - Clears to 0 in the cycle DMA is granted.
  - Holds when dma_req = 0.
- Protocol violation: if req drops before ack, the granted transaction still completes and ack still pulses.
- Requests arriving while busy wait; they are not queued beyond the req level.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, ISSUE, RESP, DONE);
  - the IO_PREFIX constant and the address-map constants (HEX F0000000, LEDR F0000004, LEDG F0000008, KEY F0000010, SW F0000014, TIMER F0000020).
- One sub-module, starve_counter: a saturating counter with inc, clr and at_limit signals.

Test Plan:
- CPU write to 0x00000100 with data 0xDEADBEEF, DMA idle -> mem_we = 1 only in cycle 1 with bus_addr 0x100; cpu_ack pulses in cycle 2; io_we stays 0.
- CPU write to 0xF0000004 with data 0x3FF -> io_we = 1 and mem_we = 0 in ISSUE; cpu_ack one cycle later.
- CPU read of 0x100 with bus_rdata modelled as 0xDEADBEEF one cycle after bus_re -> cpu_ack and cpu_rdata = 0xDEADBEEF in cycle 3; dma_ack stays 0.
- Both requesters continuously asserting reads, STARVE_LIMIT = 8 -> CPU is granted until the count reaches 8, then DMA is granted once; count returns to 0 and CPU wins the next grant.
- CPU and DMA request in the same IDLE cycle with count = 0 -> CPU is granted; DMA is granted in the arbitration cycle immediately after cpu_ack.
- Reset driven low during RESP of a DMA read -> no dma_ack; the next cycle shows state IDLE with all strobes and both rdata registers at 0.

Source files
------------

// File: rtl/dbus_arbiter_pkg.sv
// Shared definitions for the data-bus arbiter: FSM encodings, grant ids and the I/O address map.
package dbus_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DMA = 1'b1;

  localparam int unsigned PREFIX_BITS   = 4;
  localparam logic [3:0]  IO_PREFIX_DEF = 4'hF;

  // Memory-mapped I/O register map
  localparam logic [31:0] ADDR_HEX   = 32'hF000_0000;
  localparam logic [31:0] ADDR_LEDR  = 32'hF000_0004;
  localparam logic [31:0] ADDR_LEDG  = 32'hF000_0008;
  localparam logic [31:0] ADDR_KEY   = 32'hF000_0010;
  localparam logic [31:0] ADDR_SW    = 32'hF000_0014;
  localparam logic [31:0] ADDR_TIMER = 32'hF000_0020;

  function automatic logic is_io_prefix(input logic [3:0] prefix, input logic [3:0] io_prefix);
    return prefix == io_prefix;
  endfunction

endpackage

// File: rtl/dbus_arbiter_starve_counter.sv
// Saturating count of cycles DMA has waited; at_limit tracks count >= LIMIT, registered.
module dbus_arbiter_starve_counter #(
  parameter int unsigned CNT_BITS = 4,
  parameter int unsigned LIMIT    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] LIMIT_V = CNT_BITS'(LIMIT);

  logic [CNT_BITS-1:0] count;
  logic [CNT_BITS-1:0] count_d;

  // clr wins over inc so a DMA grant always restarts the wait count
  always_comb begin
    count_d = count;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count != CNT_MAX)) begin
      count_d = count + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count    <= '0;
      at_limit <= (LIMIT_V == '0);
    end else begin
      count    <= count_d;
      at_limit <= (count_d >= LIMIT_V);
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-port (CPU, DMA) arbiter and sequencer for the shared data-memory / MMIO bus.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int unsigned DBITS        = 32,
  parameter logic [3:0]  IO_PREFIX    = IO_PREFIX_DEF,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_BITS     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [DBITS-1:0] cpu_addr,
  input  logic [DBITS-1:0] cpu_wdata,
  output logic             cpu_ack,
  output logic [DBITS-1:0] cpu_rdata,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [DBITS-1:0] dma_addr,
  input  logic [DBITS-1:0] dma_wdata,
  output logic             dma_ack,
  output logic [DBITS-1:0] dma_rdata,
  output logic [DBITS-1:0] bus_addr,
  output logic [DBITS-1:0] bus_wdata,
  output logic             bus_re,
  output logic             mem_we,
  output logic             io_we,
  input  logic [DBITS-1:0] bus_rdata,
  output logic             busy,
  output logic             grant_id
);

  localparam int unsigned PFX_LSB = DBITS - PREFIX_BITS;

  logic [1:0]       state, state_d;
  logic             bus_we, bus_we_d;
  logic [DBITS-1:0] bus_addr_d, bus_wdata_d;
  logic [DBITS-1:0] cpu_rdata_d, dma_rdata_d;
  logic             bus_re_d, mem_we_d, io_we_d;
  logic             cpu_ack_d, dma_ack_d;
  logic             busy_d, grant_id_d;

  logic             at_limit;
  logic             cnt_inc, cnt_clr;
  logic             sel_dma;
  logic             sel_we;
  logic [DBITS-1:0] sel_addr, sel_wdata;
  logic             sel_io;

  // CPU has priority unless DMA has waited long enough
  assign sel_dma   = dma_req & (~cpu_req | at_limit);
  assign sel_we    = sel_dma ? dma_we    : cpu_we;
  assign sel_addr  = sel_dma ? dma_addr  : cpu_addr;
  assign sel_wdata = sel_dma ? dma_wdata : cpu_wdata;
  assign sel_io    = is_io_prefix(sel_addr[DBITS-1:PFX_LSB], IO_PREFIX);

  // DMA is waiting whenever it requests and is not the owner of the current transaction
  assign cnt_inc = dma_req & ~(busy & (grant_id == GNT_DMA));

  dbus_arbiter_starve_counter #(
    .CNT_BITS (CNT_BITS),
    .LIMIT    (STARVE_LIMIT)
  ) u_starve_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (cnt_inc),
    .clr      (cnt_clr),
    .at_limit (at_limit)
  );

  // Next-state and next-output logic; every output register is loaded from its _d value
  always_comb begin
    state_d     = state;
    bus_we_d    = bus_we;
    bus_addr_d  = bus_addr;
    bus_wdata_d = bus_wdata;
    cpu_rdata_d = cpu_rdata;
    dma_rdata_d = dma_rdata;
    grant_id_d  = grant_id;
    busy_d      = busy;
    bus_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    io_we_d     = 1'b0;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    cnt_clr     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cpu_req || dma_req) begin
          state_d     = ST_ISSUE;
          busy_d      = 1'b1;
          grant_id_d  = sel_dma ? GNT_DMA : GNT_CPU;
          bus_we_d    = sel_we;
          bus_addr_d  = sel_addr;
          bus_wdata_d = sel_wdata;
          io_we_d     = sel_we & sel_io;
          mem_we_d    = sel_we & ~sel_io;
          bus_re_d    = ~sel_we;
          cnt_clr     = sel_dma;
        end
      end

      ST_ISSUE: begin
        if (bus_we) begin
          state_d   = ST_DONE;
          cpu_ack_d = (grant_id == GNT_CPU);
          dma_ack_d = (grant_id == GNT_DMA);
        end else begin
          state_d = ST_RESP;
        end
      end

      // bus_rdata is valid this cycle, one cycle after bus_re
      ST_RESP: begin
        state_d = ST_DONE;
        if (grant_id == GNT_DMA) begin
          dma_rdata_d = bus_rdata;
          dma_ack_d   = 1'b1;
        end else begin
          cpu_rdata_d = bus_rdata;
          cpu_ack_d   = 1'b1;
        end
      end

      // Always return to IDLE so a requester that drops req after ack is not re-granted
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      grant_id  <= 1'b0;
      busy      <= 1'b0;
      bus_re    <= 1'b0;
      mem_we    <= 1'b0;
      io_we     <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
    end else begin
      state     <= state_d;
      bus_we    <= bus_we_d;
      bus_addr  <= bus_addr_d;
      bus_wdata <= bus_wdata_d;
      cpu_rdata <= cpu_rdata_d;
      dma_rdata <= dma_rdata_d;
      grant_id  <= grant_id_d;
      busy      <= busy_d;
      bus_re    <= bus_re_d;
      mem_we    <= mem_we_d;
      io_we     <= io_we_d;
      cpu_ack   <= cpu_ack_d;
      dma_ack   <= dma_ack_d;
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: expected acks queued at request time, matched by a negedge monitor.
module tb_dbus_arbiter;
  import dbus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic        dma_ack;
  logic [31:0] dma_rdata;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_re, mem_we, io_we;
  logic [31:0] bus_rdata = '0;
  logic        busy, grant_id;

  dbus_arbiter #(
    .DBITS        (32),
    .IO_PREFIX    (4'hF),
    .STARVE_LIMIT (8),
    .CNT_BITS     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_re    (bus_re),
    .mem_we    (mem_we),
    .io_we     (io_we),
    .bus_rdata (bus_rdata),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] fill(input logic [7:0] idx);
    return 32'hA5A5_0000 | 32'(idx);
  endfunction

  // Memory model on the bus side: responds one cycle after bus_re
  logic [31:0]  bus_mem [256];
  logic [255:0] bus_vld = '0;
  always @(posedge clk) begin
    if (bus_re)
      bus_rdata <= bus_vld[bus_addr[9:2]] ? bus_mem[bus_addr[9:2]] : fill(bus_addr[9:2]);
    if (mem_we) begin
      bus_mem[bus_addr[9:2]] <= bus_wdata;
      bus_vld[bus_addr[9:2]] <= 1'b1;
    end
  end

  // Reference memory, updated when stimulus is issued
  logic [31:0]  ref_mem [256];
  logic [255:0] ref_vld = '0;

  typedef struct {
    int          port;
    bit          rd;
    logic [31:0] data;
    int unsigned ack_cyc;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input int port, input bit rd, input logic [31:0] data, input int unsigned ack_cyc);
    exp_t e;
    e.port = port; e.rd = rd; e.data = data; e.ack_cyc = ack_cyc;
    exp_q.push_back(e);
  endtask

  // Monitor: each ack must match the head of the scoreboard
  logic [31:0] last_rd [2];
  exp_t        mon_e;
  always @(negedge clk) begin
    check_eq("we_excl", 32'(mem_we & io_we), 32'd0);
    if (!reset) begin
      last_rd[0] = '0;
      last_rd[1] = '0;
    end
    if (cpu_ack || dma_ack) begin
      if (exp_q.size() == 0) begin
        check_eq("unexp_ack", {30'd0, dma_ack, cpu_ack}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("ack_port", {30'd0, dma_ack, cpu_ack}, (mon_e.port == 1) ? 32'd2 : 32'd1);
        check_eq("ack_cyc", cyc, mon_e.ack_cyc);
        if (mon_e.rd) last_rd[mon_e.port] = mon_e.data;
        check_eq("rdata", (mon_e.port == 1) ? dma_rdata : cpu_rdata, last_rd[mon_e.port]);
      end
    end
  end

  // Present a request in an IDLE cycle; queue its expected ack unless the test aborts it
  task automatic drive_req(input int port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int unsigned extra, input bit push);
    logic [7:0]  idx;
    logic [31:0] rd_val;
    @(negedge clk); #1;
    idx    = addr[9:2];
    rd_val = ref_vld[idx] ? ref_mem[idx] : fill(idx);
    if (push) begin
      push_exp(port, !we, we ? 32'd0 : rd_val, cyc + (we ? 2 : 3) + extra);
      if (we && addr[31:28] != IO_PREFIX_DEF) begin
        ref_mem[idx] = wdata;
        ref_vld[idx] = 1'b1;
      end
    end
    if (port == 0) begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end else begin
      dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
    end
  endtask

  // Check the ISSUE cycle (after skip waiting cycles) and the cycle that follows it
  task automatic check_issue(input int port, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int skip);
    bit io;
    io = (addr[31:28] == IO_PREFIX_DEF);
    repeat (skip) @(negedge clk);
    @(negedge clk);
    check_eq("issue_busy", 32'(busy), 32'd1);
    check_eq("issue_grant", 32'(grant_id), 32'(port));
    check_eq("issue_addr", bus_addr, addr);
    check_eq("issue_mem_we", 32'(mem_we), 32'(we & !io));
    check_eq("issue_io_we", 32'(io_we), 32'(we & io));
    check_eq("issue_re", 32'(bus_re), 32'(!we));
    if (we) check_eq("issue_wdata", bus_wdata, wdata);
    @(negedge clk); #1;
    check_eq("post_strobes", {29'd0, bus_re, mem_we, io_we}, 32'd0);
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = (exp_q.size() == 0);
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk); #1;
      done = (exp_q.size() == 0);
    end
    check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic drop_all();
    cpu_req = 1'b0;
    dma_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_strobes", {27'd0, bus_re, mem_we, io_we, cpu_ack, dma_ack}, 32'd0);
    check_eq("rst_bus_addr", bus_addr, 32'd0);
    check_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
    check_eq("rst_dma_rdata", dma_rdata, 32'd0);
    reset = 1'b1;

    // CPU memory write, I/O write, and read back
    drive_req(0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1'b1);
    check_issue(0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 0);
    wait_drain(10); drop_all();

    drive_req(0, 1'b1, ADDR_LEDR, 32'h0000_03FF, 0, 1'b1);
    check_issue(0, 1'b1, ADDR_LEDR, 32'h0000_03FF, 0);
    wait_drain(10); drop_all();

    drive_req(0, 1'b0, 32'h0000_0100, 32'd0, 0, 1'b1);
    check_issue(0, 1'b0, 32'h0000_0100, 32'd0, 0);
    wait_drain(10); drop_all();

    // Simultaneous requests with an empty wait count: CPU first, DMA right after cpu_ack
    @(negedge clk); #1;
    s = cyc;
    push_exp(0, 1'b0, 32'd0, s + 2);
    push_exp(1, 1'b0, 32'd0, s + 5);
    ref_mem[8'h80] = 32'h1234_5678; ref_vld[8'h80] = 1'b1;
    cpu_we = 1'b1; cpu_addr = 32'h0000_0200; cpu_wdata = 32'h1234_5678; cpu_req = 1'b1;
    dma_we = 1'b1; dma_addr = ADDR_LEDG; dma_wdata = 32'h0000_0055; dma_req = 1'b1;
    check_issue(0, 1'b1, 32'h0000_0200, 32'h1234_5678, 0);
    cpu_req = 1'b0;
    check_issue(1, 1'b1, ADDR_LEDG, 32'h0000_0055, 1);
    wait_drain(10); drop_all();

    // Continuous reads from both: wait count hits 8 after two CPU reads, so the order is C C D repeating
    @(negedge clk); #1;
    s = cyc;
    for (int k = 0; k < 6; k++) begin
      if (k % 3 == 2) push_exp(1, 1'b1, fill(8'hC0), s + 3 + 4 * k);
      else            push_exp(0, 1'b1, 32'h1234_5678, s + 3 + 4 * k);
    end
    cpu_we = 1'b0; cpu_addr = 32'h0000_0200; cpu_req = 1'b1;
    dma_we = 1'b0; dma_addr = 32'h0000_0300; dma_req = 1'b1;
    wait_drain(40); drop_all();

    // Reset during RESP of a DMA read aborts it
    drive_req(1, 1'b0, 32'h0000_0104, 32'd0, 0, 1'b0);
    check_issue(1, 1'b0, 32'h0000_0104, 32'd0, 0);
    reset = 1'b0;
    dma_req = 1'b0;
    @(negedge clk); #1;
    check_eq("abort_dma_ack", 32'(dma_ack), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_strobes", {29'd0, bus_re, mem_we, io_we}, 32'd0);
    check_eq("abort_cpu_rdata", cpu_rdata, 32'd0);
    check_eq("abort_dma_rdata", dma_rdata, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Recovery after reset: DMA I/O write
    drive_req(1, 1'b1, ADDR_TIMER, 32'h0000_002A, 0, 1'b1);
    check_issue(1, 1'b1, ADDR_TIMER, 32'h0000_002A, 0);
    wait_drain(10); drop_all();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
